// File: rtl/axis_mon_pkg.sv
// axis_mon_pkg: shared types for the AXI4-Stream monitor.
// Beat layout, error bit indices and packet FSM states.
package axis_mon_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;
    localparam int ID_W   = 4;
    localparam int DEST_W = 4;
    localparam int USER_W = 1;

    localparam int ERR_W          = 5;
    localparam int ERR_VALID_DROP = 0;
    localparam int ERR_PAYLOAD    = 1;
    localparam int ERR_STRB_KEEP  = 2;
    localparam int ERR_PKT_HDR    = 3;
    localparam int ERR_TIMEOUT    = 4;

    // Flat width of one captured beat for arbitrary bus widths
    function automatic int beat_width(
        input int dw,
        input int iw,
        input int dsw,
        input int uw
    );
        return dw + 2 * (dw / 8) + 1 + iw + dsw + uw;
    endfunction

    // Field order matches the flat vector packed by the monitor
    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tstrb;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
        logic [ID_W-1:0]   tid;
        logic [DEST_W-1:0] tdest;
        logic [USER_W-1:0] tuser;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/axis_mon_if.sv
// axis_mon_if: AXI4-Stream link signals.
// master/slave for the link ends, mon for the passive tap.
interface axis_mon_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
);

    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TSTRB;
    logic [DATA_WIDTH/8-1:0] TKEEP;
    logic                    TLAST;
    logic [ID_WIDTH-1:0]     TID;
    logic [DEST_WIDTH-1:0]   TDEST;
    logic [USER_WIDTH-1:0]   TUSER;

    modport master (
        output TVALID, TDATA, TSTRB, TKEEP,
        output TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TSTRB, TKEEP,
        input  TLAST, TID, TDEST, TUSER,
        output TREADY
    );

    modport mon (
        input TVALID, TREADY, TDATA, TSTRB,
        input TKEEP, TLAST, TID, TDEST, TUSER
    );

endinterface

// File: rtl/axis_mon_fifo.sv
// axis_mon_fifo: synchronous capture FIFO with flush.
// A push is accepted when full if a pop happens in the same cycle.
module axis_mon_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty & ~i_flush;
    assign w_push  = i_push & (~w_full | w_pop) & ~i_flush;

    // Read/write pointers with wrap bit; flush empties the queue
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axis_stream_monitor.sv
// axis_stream_monitor: passive AXI4-Stream tap, beat capture and checker.
// Optional stall watchdog enabled by defining AXIS_MON_STALL_TIMEOUT_EN.
module axis_stream_monitor
    import axis_mon_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int TREADY_EN  = 1
`ifdef AXIS_MON_STALL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axis_mon_if.mon              bus,
    input  logic                 clr,
    output logic                 cap_valid,
    input  logic                 cap_ready,
    output logic [beat_width(DATA_WIDTH, ID_WIDTH,
                             DEST_WIDTH, USER_WIDTH)-1:0] cap_beat,
    output logic                 cap_overflow,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [ERR_W-1:0]     err_flags
);

    localparam int BEAT_W = beat_width(DATA_WIDTH, ID_WIDTH,
                                       DEST_WIDTH, USER_WIDTH);
    localparam logic RDY_EN = (TREADY_EN != 0);

    logic                  w_xfer;
    logic                  w_stall;
    logic                  w_push;
    logic                  w_fifo_full;
    logic                  w_drop;
    logic                  w_to_hit;
    logic [BEAT_W-1:0]     w_pay;
    logic [ERR_W-1:0]      w_err;

    logic                  r_stall_q;
    logic [BEAT_W-1:0]     r_pay;
    pkt_state_e            r_state;
    pkt_state_e            w_state_nxt;
    logic                  w_hdr_latch;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [ERR_W-1:0]      r_err;
    logic                  r_ovf;

    assign w_pay = {bus.TDATA, bus.TSTRB, bus.TKEEP, bus.TLAST,
                    bus.TID, bus.TDEST, bus.TUSER};

    // Without TREADY on the link every valid cycle transfers
    assign w_xfer  = bus.TVALID & (bus.TREADY | ~RDY_EN);
    assign w_stall = RDY_EN & bus.TVALID & ~bus.TREADY;
    assign w_push  = w_xfer & ~clr;
    assign w_drop  = w_push & w_fifo_full & ~cap_ready;

    // Hold the payload seen on the first cycle of a stall
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_stall_q <= 1'b0;
            r_pay     <= '0;
        end else if (clr) begin
            r_stall_q <= 1'b0;
        end else begin
            r_stall_q <= w_stall;
            if (w_stall & ~r_stall_q) r_pay <= w_pay;
        end
    end

    // Packet FSM next state; header latched on a packet's first beat
    always_comb begin
        w_state_nxt = r_state;
        w_hdr_latch = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_xfer & ~bus.TLAST) begin
                        w_state_nxt = IN_PKT;
                        w_hdr_latch = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (w_xfer & bus.TLAST) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Packet FSM state and latched TID/TDEST
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_latch) begin
                r_id   <= bus.TID;
                r_dest <= bus.TDEST;
            end
        end
    end

`ifdef AXIS_MON_STALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Saturating count of consecutive stall cycles
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_to_cnt <= '0;
        end else if (clr | ~w_stall) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_to_hit = w_stall &
                      (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    // Violations detected this cycle
    always_comb begin
        w_err = '0;
        w_err[ERR_VALID_DROP] = r_stall_q & ~bus.TVALID;
        w_err[ERR_PAYLOAD]    = r_stall_q & bus.TVALID &
                                (w_pay != r_pay);
        w_err[ERR_STRB_KEEP]  = w_xfer &
                                (|(bus.TSTRB & ~bus.TKEEP));
        w_err[ERR_PKT_HDR]    = w_xfer & (r_state == IN_PKT) &
                                ((bus.TID != r_id) |
                                 (bus.TDEST != r_dest));
        w_err[ERR_TIMEOUT]    = w_to_hit;
    end

    // Sticky error flags and overflow
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_err <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_err <= r_err | w_err;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Beat and packet counters, wrapping
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (clr) begin
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            if (bus.TLAST) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
        end
    end

    axis_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_flush (clr),
        .i_push  (w_push),
        .i_pop   (cap_ready),
        .i_data  (w_pay),
        .o_valid (cap_valid),
        .o_full  (w_fifo_full),
        .o_data  (cap_beat)
    );

    assign cap_overflow = r_ovf;
    assign beat_cnt     = r_beat_cnt;
    assign pkt_cnt      = r_pkt_cnt;
    assign err_flags    = r_err;

endmodule

// File: tb/tb_axis_stream_monitor.sv
// tb_axis_stream_monitor: directed table plus hand sequences.
// Unit A uses TREADY, unit B ignores it; both tap the same bus.
module tb_axis_stream_monitor;
    import axis_mon_pkg::*;

`ifdef AXIS_MON_STALL_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        cap_ready;
    logic        a_cv, b_cv;
    beat_t       a_beat, b_beat;
    logic        a_ovf, b_ovf;
    logic [31:0] a_bc, a_pc, b_bc, b_pc;
    logic [4:0]  a_err, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    axis_mon_if #(
        .DATA_WIDTH(32), .ID_WIDTH(4),
        .DEST_WIDTH(4), .USER_WIDTH(1)
    ) bus ();

    axis_stream_monitor #(
        .TREADY_EN(1)
`ifdef AXIS_MON_STALL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) u_dut_a (
        .ACLK(clk), .ARESETn(rst_n), .bus(bus), .clr(clr),
        .cap_valid(a_cv), .cap_ready(cap_ready),
        .cap_beat(a_beat), .cap_overflow(a_ovf),
        .beat_cnt(a_bc), .pkt_cnt(a_pc), .err_flags(a_err)
    );

    axis_stream_monitor #(
        .TREADY_EN(0)
    ) u_dut_b (
        .ACLK(clk), .ARESETn(rst_n), .bus(bus), .clr(clr),
        .cap_valid(b_cv), .cap_ready(cap_ready),
        .cap_beat(b_beat), .cap_overflow(b_ovf),
        .beat_cnt(b_bc), .pkt_cnt(b_pc), .err_flags(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    typedef struct {
        logic        v, r;
        logic [31:0] d;
        logic [3:0]  s, k;
        logic        l;
        logic [3:0]  id, de;
        logic        c, cr;
        logic [31:0] e_bc, e_pc;
        logic [4:0]  e_err;
        logic        e_cv;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, r, input logic [31:0] d,
        input logic [3:0] s, k, input logic l,
        input logic [3:0] id, de, input logic c, cr,
        input logic [31:0] e_bc, e_pc, input logic [4:0] e_err,
        input logic e_cv, input logic [31:0] e_d
    );
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.s = s; t.k = k; t.l = l;
        t.id = id; t.de = de; t.c = c; t.cr = cr;
        t.e_bc = e_bc; t.e_pc = e_pc; t.e_err = e_err;
        t.e_cv = e_cv; t.e_d = e_d;
        return t;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, r, input logic [31:0] d,
                         input logic [3:0] s, k, input logic l,
                         input logic [3:0] id, de);
        bus.TVALID = v; bus.TREADY = r; bus.TDATA = d;
        bus.TSTRB = s; bus.TKEEP = k; bus.TLAST = l;
        bus.TID = id; bus.TDEST = de; bus.TUSER = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22;
        exp_d[2] = 32'h33; exp_d[3] = 32'h44;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0;
        exp_l[2] = 1'b0; exp_l[3] = 1'b1;

        // 4-beat packet
        tbl.push_back(mk(1,1,32'h11,4'hF,4'hF,0,1,2,0,0, 1,0,0,1,32'h11));
        tbl.push_back(mk(1,1,32'h22,4'hF,4'hF,0,1,2,0,0, 2,0,0,1,32'h11));
        tbl.push_back(mk(1,1,32'h33,4'hF,4'hF,0,1,2,0,0, 3,0,0,1,32'h11));
        tbl.push_back(mk(1,1,32'h44,4'hF,4'hF,1,1,2,0,0, 4,1,0,1,32'h11));
        // payload change during stall
        tbl.push_back(mk(1,0,32'hA5,4'hF,4'hF,1,1,2,0,0, 4,1,0,0,0));
        tbl.push_back(mk(1,0,32'h5A,4'hF,4'hF,1,1,2,0,0, 4,1,2,0,0));
        tbl.push_back(mk(1,0,32'h5A,4'hF,4'hF,1,1,2,0,0, 4,1,2,0,0));
        tbl.push_back(mk(1,1,32'h5A,4'hF,4'hF,1,1,2,0,1, 5,2,2,1,32'h5A));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0));
        // valid dropped after stall
        tbl.push_back(mk(1,0,32'h77,4'hF,4'hF,1,1,2,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0,32'h77,4'hF,4'hF,1,1,2,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0));
        // strb/keep and header change
        tbl.push_back(mk(1,1,32'h55,4'h8,4'h7,0,1,2,0,0, 1,0,4,1,32'h55));
        tbl.push_back(mk(1,1,32'h66,4'hF,4'hF,1,2,2,0,0, 2,1,12,1,32'h55));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0));
        // clean packets, single-beat packet stays idle
        tbl.push_back(mk(1,1,32'h1,4'hF,4'hF,0,3,3,0,0, 1,0,0,1,32'h1));
        tbl.push_back(mk(1,1,32'h2,4'hF,4'hF,1,3,3,0,0, 2,1,0,1,32'h1));
        tbl.push_back(mk(1,1,32'h3,4'hF,4'hF,1,5,5,0,0, 3,2,0,1,32'h1));
        tbl.push_back(mk(1,1,32'h4,4'hF,4'hF,0,6,6,0,0, 4,2,0,1,32'h1));
        tbl.push_back(mk(1,1,32'h5,4'hF,4'hF,1,6,6,0,0, 5,3,0,1,32'h1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0));

        // reset
        rst_n = 1'b0; clr = 1'b0; cap_ready = 1'b0;
        idle();
        tick(); tick();
        chk("rst beat_cnt", 64'(a_bc), 0);
        chk("rst pkt_cnt", 64'(a_pc), 0);
        chk("rst err", 64'(a_err), 0);
        chk("rst cap_valid", 64'(a_cv), 0);
        chk("rst ovf", 64'(a_ovf), 0);
        chk("rst cap_beat", 64'(a_beat), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].s,
                  tbl[i].k, tbl[i].l, tbl[i].id, tbl[i].de);
            clr = tbl[i].c;
            cap_ready = tbl[i].cr;
            tick();
            chk($sformatf("v%0d beat_cnt", i), 64'(a_bc), 64'(tbl[i].e_bc));
            chk($sformatf("v%0d pkt_cnt", i), 64'(a_pc), 64'(tbl[i].e_pc));
            chk($sformatf("v%0d err", i), 64'(a_err), 64'(tbl[i].e_err));
            chk($sformatf("v%0d cap_valid", i), 64'(a_cv), 64'(tbl[i].e_cv));
            if (tbl[i].e_cv)
                chk($sformatf("v%0d cap_data", i),
                    64'(a_beat.tdata), 64'(tbl[i].e_d));
            if (i == 3) begin
                idle();
                cap_ready = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("pkt pop%0d data", j),
                        64'(a_beat.tdata), 64'(exp_d[j]));
                    chk($sformatf("pkt pop%0d last", j),
                        64'(a_beat.tlast), 64'(exp_l[j]));
                    tick();
                end
                chk("pkt drained", 64'(a_cv), 0);
                cap_ready = 1'b0;
            end
        end
        clr = 1'b0;
        cap_ready = 1'b0;

        // overflow: 10 beats into 8 entries
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 32'(i), 4'hF, 4'hF, 1, 0, 0);
            tick();
        end
        idle();
        chk("ovf beat_cnt", 64'(a_bc), 10);
        chk("ovf pkt_cnt", 64'(a_pc), 10);
        chk("ovf flag", 64'(a_ovf), 1);
        cap_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf pop%0d", i), 64'(a_beat.tdata), 64'(i));
            tick();
        end
        chk("ovf drained", 64'(a_cv), 0);
        chk("ovf sticky", 64'(a_ovf), 1);
        cap_ready = 1'b0;
        do_clr();
        chk("ovf clr", 64'(a_ovf), 0);

        // full with simultaneous pop accepts the push
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h100 + 32'(i), 4'hF, 4'hF, 1, 0, 0);
            tick();
        end
        drive(1, 1, 32'h200, 4'hF, 4'hF, 1, 0, 0);
        cap_ready = 1'b1;
        tick();
        idle();
        chk("fullpop ovf", 64'(a_ovf), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpop pop%0d", i), 64'(a_beat.tdata),
                (i == 7) ? 64'h200 : 64'h101 + 64'(i));
            tick();
        end
        chk("fullpop drained", 64'(a_cv), 0);
        cap_ready = 1'b0;
        do_clr();

        // no-TREADY link: every valid cycle is a beat
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h30 + 32'(i), 4'hF, 4'hF, 1, 0, 0);
            tick();
        end
        chk("nordy beat_cnt", 64'(b_bc), 5);
        chk("nordy pkt_cnt", 64'(b_pc), 5);
        chk("nordy err", 64'(b_err), 0);
        chk("nordy a beat_cnt", 64'(a_bc), 0);
        do_clr();

        // stall watchdog
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'hC3, 4'hF, 4'hF, 1, 0, 0);
            tick();
        end
        drive(1, 1, 32'hC3, 4'hF, 4'hF, 1, 0, 0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 32'hC3, 4'hF, 4'hF, 1, 0, 0);
            tick();
        end
        chk("wdog 15 stalls", 64'(a_err), 0);
        tick();
        chk("wdog 16 stalls", 64'(a_err), {59'd0, TO_EN, 4'd0});
        do_clr();
        chk("wdog clr", 64'(a_err), 0);

        // reset mid-packet and mid-stall
        drive(1, 1, 32'hE1, 4'hF, 4'hF, 0, 1, 1);
        tick();
        drive(1, 0, 32'hE2, 4'hF, 4'hF, 1, 1, 1);
        tick();
        rst_n = 1'b0;
        idle();
        #2;
        chk("async rst beat_cnt", 64'(a_bc), 0);
        rst_n = 1'b1;
        tick();
        drive(1, 1, 32'hE3, 4'hF, 4'hF, 1, 9, 9);
        tick();
        idle();
        chk("post rst beat_cnt", 64'(a_bc), 1);
        chk("post rst pkt_cnt", 64'(a_pc), 1);
        chk("post rst err", 64'(a_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
